// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial WIDTH-bit adder, LSB first, valid/ready on both sides; macro SERIAL_ADDER_SUB_EN adds port sub (a-b mode); ports clk, rst, in_valid/in_ready/a/b/c_in[/sub], out_valid/out_ready/sum/carry, busy
module serial_adder_fa (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] ra, rb, b_ld;
  logic [5:0] cnt;
  logic c_ld, fs, fc, acc, last;
`ifdef SERIAL_ADDER_SUB_EN
  assign b_ld = sub ? ~b : b;
  assign c_ld = sub | c_in;
`else
  assign b_ld = b;
  assign c_ld = c_in;
`endif
  serial_adder_fa u_fa (.x(ra[0]), .y(rb[0]), .ci(carry), .s(fs), .co(fc));
  assign acc  = in_valid & in_ready;
  assign last = cnt == 6'(WIDTH - 1);
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    in_ready  = state == IDLE;
    busy      = state == ADD;
    out_valid = state == DONE;
    state_nx  = state == IDLE ? (in_valid ? ADD : IDLE) :
                state == ADD  ? (last ? DONE : ADD) :
                (out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk)
    if (rst) begin
      ra    <= '0;
      rb    <= '0;
      cnt   <= '0;
      sum   <= '0;
      carry <= 1'b0;
    end else if (acc) begin
      ra    <= a;
      rb    <= b_ld;
      carry <= c_ld;
      cnt   <= '0;
    end else if (busy) begin
      ra    <= ra >> 1;
      rb    <= rb >> 1;
      carry <= fc;
      sum   <= (sum >> 1) | (WIDTH'(fs) << (WIDTH - 1));
      cnt   <= cnt + 6'd1;
    end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed scoreboard bench for serial_adder_ctrl (WIDTH=8)
module tb_serial_adder_ctrl;
  localparam int W = 8;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 1, c_in = 0, sub = 0;
  logic [W-1:0] a = 0, b = 0, sum;
  logic in_ready, out_valid, carry, busy;
  logic [W:0] q[$];
  int tests = 0, fails = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c_in(c_in),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .carry(carry), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] x, y, input logic ci, s);
    return s ? {1'b0, x} + {1'b0, ~y} + (W+1)'(1) : {1'b0, x} + {1'b0, y} + (W+1)'(ci);
  endfunction

  task automatic check_result(input string tag);
    logic [W:0] e;
    if (q.size() == 0) begin
      chk({tag, "_queue"}, 1, 0);
      return;
    end
    e = q.pop_front();
    chk(tag, {carry, sum}, e);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] ta, tb_, input logic tc, ts, input int stall);
    int lat, nb;
    logic [W:0] held;
    @(negedge clk);
    chk({tag, "_rdy"}, in_ready, 1);
    a = ta; b = tb_; c_in = tc; sub = ts; in_valid = 1;
    q.push_back(model(ta, tb_, tc, ts));
    @(negedge clk);
    in_valid = 0;
    a = ~ta; b = $urandom; c_in = ~tc;
    lat = 0; nb = 0;
    while (!out_valid && lat < 50) begin
      if (busy) nb++;
      lat++;
      @(negedge clk);
    end
    chk({tag, "_lat"}, lat, W);
    chk({tag, "_busy"}, nb, W);
    held = {carry, sum};
    check_result(tag);
    if (stall > 0) begin
      out_ready = 0;
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        chk({tag, "_stall_ov"}, out_valid, 1);
        chk({tag, "_stall_rdy"}, in_ready, 0);
        chk({tag, "_stall_res"}, {carry, sum}, held);
      end
      out_ready = 1;
    end
    @(negedge clk);
    chk({tag, "_drain_rdy"}, in_ready, 1);
    chk({tag, "_drain_ov"}, out_valid, 0);
    chk({tag, "_keep"}, {carry, sum}, held);
  endtask

  initial begin
    int t[2], nacc, nres;
    logic pend;
    repeat (3) @(negedge clk);
    rst = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_rdy", in_ready, 1);
      chk("idle_ov", out_valid, 0);
      chk("idle_busy", busy, 0);
      chk("idle_sum", sum, 0);
      chk("idle_carry", carry, 0);
    end

    run_op("ff_01", 8'hFF, 8'h01, 0, 0, 0);
    run_op("5a_25", 8'h5A, 8'h25, 1, 0, 10);

    // back-to-back with in_valid held high
    nacc = 0; nres = 0; pend = 0;
    a = 8'h10; b = 8'h20; c_in = 0; sub = 0; in_valid = 1;
    q.push_back(model(8'h10, 8'h20, 0, 0));
    for (int i = 0; i < 60 && nres < 2; i++) begin
      if (pend) begin
        pend = 0;
        if (nacc == 1) begin
          a = 8'h7F; b = 8'h7F;
          q.push_back(model(8'h7F, 8'h7F, 0, 0));
        end else in_valid = 0;
      end
      if (out_valid) begin
        check_result("b2b");
        nres++;
      end
      if (in_valid && in_ready && nacc < 2) begin
        t[nacc] = i;
        nacc++;
        pend = 1;
      end
      @(negedge clk);
    end
    in_valid = 0;
    chk("b2b_results", nres, 2);
    chk("b2b_accepts", nacc, 2);
    chk("b2b_spacing", t[1] - t[0], W + 2);

    // reset during the 4th ADD cycle discards the operation
    @(negedge clk);
    a = 8'hAA; b = 8'h55; c_in = 0; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    repeat (3) @(negedge clk);
    chk("rst_mid_busy", busy, 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("rst_rdy", in_ready, 1);
    chk("rst_ov", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sum", sum, 0);
    chk("rst_carry", carry, 0);
    begin
      int seen = 0;
      for (int i = 0; i < 15; i++) begin
        @(negedge clk);
        if (out_valid) seen++;
      end
      chk("rst_no_ov", seen, 0);
    end
    run_op("01_01", 8'h01, 8'h01, 0, 0, 0);
    run_op("c0_3f", 8'hC0, 8'h3F, 1, 0, 2);
`ifdef SERIAL_ADDER_SUB_EN
    run_op("sub_5_7", 8'h05, 8'h07, 0, 1, 0);
    run_op("sub_7_5", 8'h07, 8'h05, 1, 1, 0);
`endif
    chk("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
